// File: rtl/cereal_rx.sv
// cereal_rx: oversampling 8N1 UART receiver feeding the tweetboard store path.
// Synchronises the raw line, confirms the start bit at mid-bit, samples each
// data bit at mid-bit, and hands bytes over through a one-entry holding
// register with a valid/ready handshake. Framing errors and overruns are
// reported as one-cycle pulses.
module cereal_rx #(
  parameter int CLKS_PER_BIT = 5207,
  parameter int CNT_W        = 13
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       serialIn,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state;
  logic             sync1;
  logic             rx_s;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             deliver_pend;

  // Two-flop synchroniser; the line idles high so both flops reset to 1.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= serialIn;
      rx_s  <= sync1;
    end
  end

  // Frame FSM: start check at half a bit, data and stop sampled at mid-bit.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      clk_cnt      <= '0;
      bit_idx      <= 3'd0;
      shreg        <= 8'h00;
      rx_busy      <= 1'b0;
      frame_err    <= 1'b0;
      deliver_pend <= 1'b0;
    end else begin
      frame_err    <= 1'b0;
      deliver_pend <= 1'b0;
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_idx <= 3'd0;
          if (!rx_s) begin
            state   <= START;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (clk_cnt == HALF_M1) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (clk_cnt == FULL_M1) begin
            clk_cnt <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (clk_cnt == FULL_M1) begin
            clk_cnt <= '0;
            if (rx_s) begin
              state        <= IDLE;
              rx_busy      <= 1'b0;
              deliver_pend <= 1'b1;
            end else begin
              state     <= BREAK;
              frame_err <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        BREAK: begin
          clk_cnt <= '0;
          if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          clk_cnt <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

  // Holding register: accept a finished byte if empty or drained this cycle.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (deliver_pend) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cereal_rx.sv
// tb_cereal_rx: directed bench for cereal_rx with a byte scoreboard.
// Expected bytes are queued as frames are sent and matched against every
// delivery the monitor observes on the holding register.
module tb_cereal_rx;

  localparam int CPB   = 16;
  localparam int CNT_W = 5;

  logic       sysclk;
  logic       reset;
  logic       serialIn;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  int         obs_cnt = 0;
  logic [7:0] obs_data [64];
  int         obs_cyc [64];
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         busy_cycles = 0;
  logic       prev_valid = 1'b0;
  logic       prev_hs = 1'b0;

  logic [7:0] exp_q [$];
  int         rd_idx = 0;

  cereal_rx #(
    .CLKS_PER_BIT(CPB),
    .CNT_W(CNT_W)
  ) dut (
    .sysclk(sysclk),
    .reset(reset),
    .serialIn(serialIn),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .rx_busy(rx_busy),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  // Cycle counter used for latency measurement.
  always @(posedge sysclk) cyc <= cyc + 1;

  // Monitor on the falling edge: record deliveries and count pulses.
  always @(negedge sysclk) begin
    if (rx_valid && (!prev_valid || prev_hs)) begin
      if (obs_cnt < 64) begin
        obs_data[obs_cnt] = rx_data;
        obs_cyc[obs_cnt]  = cyc;
      end
      obs_cnt++;
    end
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (rx_busy) busy_cycles++;
    prev_valid = rx_valid;
    prev_hs    = rx_valid && rx_ready;
  end

  // Watchdog so the bench can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    cmp_cnt++;
    assert (observed === expected)
    else begin
      err_cnt++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // Drive one 8N1 frame LSB first; the line is left at the stop-bit level.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    serialIn = 1'b0;
    waitCycles(CPB);
    for (int i = 0; i < 8; i++) begin
      serialIn = b[i];
      waitCycles(CPB);
    end
    serialIn = stop_bit;
    waitCycles(CPB);
  endtask

  task automatic waitDeliveries(input int target, input int budget);
    int left;
    left = budget;
    while (obs_cnt < target && left > 0) begin
      waitCycles(1);
      left--;
    end
    checkOutput("delivery_count", obs_cnt, target);
  endtask

  task automatic scoreboardCheck();
    logic [7:0] e;
    while (rd_idx < obs_cnt) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_unexpected_byte", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sb_rx_data", obs_data[rd_idx], e);
      end
      rd_idx++;
    end
  endtask

  task automatic drainHolding();
    rx_ready = 1'b1;
    waitCycles(1);
    rx_ready = 1'b0;
    checkOutput("drain_valid_low", rx_valid, 0);
  endtask

  // Directed sequence of scenarios.
  initial begin
    int c0;
    int lat;
    int base_obs;
    int base_fe;
    int base_ov;
    int base_busy;

    reset    = 1'b0;
    serialIn = 1'b1;
    rx_ready = 1'b0;
    waitCycles(3);
    checkOutput("reset_rx_valid", rx_valid, 0);
    checkOutput("reset_rx_data", rx_data, 8'h00);
    checkOutput("reset_rx_busy", rx_busy, 0);
    checkOutput("reset_frame_err", frame_err, 0);
    checkOutput("reset_overrun", overrun, 0);
    reset = 1'b1;
    waitCycles(4);

    $display("[TB] byte reception 0x41");
    base_busy = busy_cycles;
    exp_q.push_back(8'h41);
    c0 = cyc;
    applyStimulus(8'h41, 1'b1);
    waitDeliveries(1, 400);
    lat = obs_cyc[0] - c0 - 1;
    checkOutput("latency_in_window", (lat >= 154 && lat <= 156), 1);
    checkOutput("busy_cycles_frame", (busy_cycles - base_busy >= 150 &&
                                      busy_cycles - base_busy <= 154), 1);
    scoreboardCheck();
    checkOutput("busy_after_frame", rx_busy, 0);
    checkOutput("valid_after_frame", rx_valid, 1);
    waitCycles(10);
    checkOutput("single_delivery", obs_cnt, 1);
    drainHolding();

    $display("[TB] glitch rejection");
    base_obs  = obs_cnt;
    base_fe   = fe_cnt;
    base_ov   = ov_cnt;
    base_busy = busy_cycles;
    serialIn  = 1'b0;
    waitCycles(3);
    serialIn = 1'b1;
    waitCycles(25);
    checkOutput("glitch_busy_seen", (busy_cycles > base_busy), 1);
    checkOutput("glitch_busy_low", rx_busy, 0);
    checkOutput("glitch_no_valid", obs_cnt, base_obs);
    checkOutput("glitch_no_frame_err", fe_cnt, base_fe);
    checkOutput("glitch_no_overrun", ov_cnt, base_ov);

    $display("[TB] framing error then recovery");
    base_obs = obs_cnt;
    base_fe  = fe_cnt;
    applyStimulus(8'h55, 1'b0);
    waitCycles(24);
    checkOutput("ferr_pulse_count", fe_cnt - base_fe, 1);
    checkOutput("ferr_no_valid", rx_valid, 0);
    checkOutput("ferr_no_delivery", obs_cnt, base_obs);
    checkOutput("ferr_break_busy", rx_busy, 1);
    serialIn = 1'b1;
    waitCycles(6);
    checkOutput("ferr_idle_after_high", rx_busy, 0);
    exp_q.push_back(8'h5A);
    applyStimulus(8'h5A, 1'b1);
    waitDeliveries(base_obs + 1, 400);
    scoreboardCheck();
    checkOutput("ferr_recover_data", rx_data, 8'h5A);
    drainHolding();

    $display("[TB] overrun");
    base_obs = obs_cnt;
    base_ov  = ov_cnt;
    exp_q.push_back(8'h61);
    applyStimulus(8'h61, 1'b1);
    applyStimulus(8'h62, 1'b1);
    waitCycles(4);
    checkOutput("ovr_pulse_count", ov_cnt - base_ov, 1);
    checkOutput("ovr_one_delivery", obs_cnt, base_obs + 1);
    scoreboardCheck();
    checkOutput("ovr_old_byte_kept", rx_data, 8'h61);
    checkOutput("ovr_valid_held", rx_valid, 1);
    drainHolding();
    checkOutput("ovr_data_held_after_drain", rx_data, 8'h61);

    $display("[TB] simultaneous drain and deliver");
    base_obs = obs_cnt;
    exp_q.push_back(8'h31);
    applyStimulus(8'h31, 1'b1);
    waitDeliveries(base_obs + 1, 400);
    scoreboardCheck();
    base_ov = ov_cnt;
    exp_q.push_back(8'h32);
    fork
      applyStimulus(8'h32, 1'b1);
      begin
        int left;
        left = 400;
        while (!rx_busy && left > 0) begin
          waitCycles(1);
          left--;
        end
        checkOutput("drain_busy_rise", rx_busy, 1);
        left = 400;
        while (rx_busy && left > 0) begin
          waitCycles(1);
          left--;
        end
        checkOutput("drain_busy_fall", rx_busy, 0);
        rx_ready = 1'b1;
        waitCycles(1);
        rx_ready = 1'b0;
      end
    join
    waitCycles(3);
    checkOutput("drain_no_overrun", ov_cnt, base_ov);
    checkOutput("drain_valid_stays", rx_valid, 1);
    checkOutput("drain_new_data", rx_data, 8'h32);
    checkOutput("drain_delivery_seen", obs_cnt, base_obs + 2);
    scoreboardCheck();

    $display("[TB] async reset mid-frame");
    base_obs = obs_cnt;
    fork
      applyStimulus(8'hFF, 1'b1);
      begin
        waitCycles(85);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst_mid_valid", rx_valid, 0);
        checkOutput("rst_mid_data", rx_data, 8'h00);
        checkOutput("rst_mid_busy", rx_busy, 0);
        checkOutput("rst_mid_frame_err", frame_err, 0);
        checkOutput("rst_mid_overrun", overrun, 0);
      end
    join
    serialIn = 1'b1;
    waitCycles(2);
    reset = 1'b1;
    waitCycles(5);
    checkOutput("rst_no_delivery", obs_cnt, base_obs);
    checkOutput("rst_valid_low", rx_valid, 0);
    checkOutput("rst_busy_low", rx_busy, 0);
    exp_q.push_back(8'h08);
    applyStimulus(8'h08, 1'b1);
    waitDeliveries(base_obs + 1, 400);
    scoreboardCheck();
    checkOutput("rst_fresh_data", rx_data, 8'h08);
    checkOutput("sb_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
